// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants: IV, round constants, block geometry and feeder FSM states.
// Imported by the message feeder, its interface and the padding helper.
package sha256_pkg;

  localparam int WORD_W    = 32;
  localparam int BLK_WORDS = 16;
  localparam int BLK_W     = WORD_W * BLK_WORDS;
  localparam int HASH_W    = 256;

  localparam logic [HASH_W-1:0] IV =
    256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {
    ST_FILL,
    ST_MARK,
    ST_PAD,
    ST_HASH,
    ST_OUT
  } state_t;

endpackage

// File: rtl/sha256_msg_feeder_if.sv
// Feeder bus bundle: message word stream in, compression-core launch/return, digest out.
// slave is the feeder's view, master is the surrounding environment's view.
interface sha256_msg_feeder_if import sha256_pkg::*;;

  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              s_last;
  logic [2:0]        s_nbytes;

  logic [HASH_W-1:0] core_H_in;
  logic [BLK_W-1:0]  core_M_in;
  logic              core_start;
  logic              core_done;
  logic [HASH_W-1:0] core_H_out;

  logic [HASH_W-1:0] digest;
  logic              digest_valid;
  logic              digest_ready;

  modport slave (
    input  s_valid, s_data, s_last, s_nbytes, core_done, core_H_out, digest_ready,
    output s_ready, core_H_in, core_M_in, core_start, digest, digest_valid
  );

  modport master (
    output s_valid, s_data, s_last, s_nbytes, core_done, core_H_out, digest_ready,
    input  s_ready, core_H_in, core_M_in, core_start, digest, digest_valid
  );

endinterface

// File: rtl/sha256_pad_word.sv
// Keeps the first nbytes bytes of a big-endian word, puts 0x80 in byte nbytes, zeroes the rest.
// Purely combinational; nbytes >= 4 passes the word through with no marker.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [2:0]        nbytes,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < nbytes) begin
        word[31-8*b -: 8] = data[31-8*b -: 8];
      end else if (3'(b) == nbytes) begin
        word[31-8*b -: 8] = 8'h80;
      end
    end
  end

endmodule

// File: rtl/sha256_msg_feeder.sv
// SHA-256 front end: buffers message words, applies padding and the 64-bit length,
// launches the core per 512-bit block and returns the final digest on valid/ready.
module sha256_msg_feeder
  import sha256_pkg::*;
#(
  parameter logic [HASH_W-1:0] H0 = IV
)(
  input  logic                clk,
  input  logic                rst_n,
  sha256_msg_feeder_if.slave  bus
);

  state_t            state, state_nx;
  state_t            ret, ret_nx;
  logic [3:0]        wi;
  logic [63:0]       len;
  logic [HASH_W-1:0] h;
  logic [HASH_W-1:0] dig;
  logic [WORD_W-1:0] blk [BLK_WORDS];
  logic              len_ok;
  logic              start;

  logic              accept;
  logic [WORD_W-1:0] padded;
  logic              wr_en;
  logic [WORD_W-1:0] wr_dat;
  logic              wi_clr;
  logic [63:0]       len_add;
  logic              h_load;
  logic              h_init;
  logic              dig_load;
  logic              mark_wr;
  logic              len_roll;

  sha256_pad_word u_pad (
    .data   (bus.s_data),
    .nbytes (bus.s_nbytes),
    .word   (padded)
  );

  assign bus.s_ready      = rst_n && (state == ST_FILL);
  assign accept           = bus.s_valid && bus.s_ready;
  assign bus.core_H_in    = h;
  assign bus.core_start   = start;
  assign bus.digest       = dig;
  assign bus.digest_valid = (state == ST_OUT);

  always_comb begin
    bus.core_M_in = '0;
    for (int k = 0; k < BLK_WORDS; k++) begin
      bus.core_M_in[BLK_W-1-WORD_W*k -: WORD_W] = blk[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_FILL;
      ret   <= ST_FILL;
    end else begin
      state <= state_nx;
      ret   <= ret_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ret_nx   = ret;
    wr_en    = 1'b0;
    wr_dat   = '0;
    wi_clr   = 1'b0;
    len_add  = '0;
    h_load   = 1'b0;
    h_init   = 1'b0;
    dig_load = 1'b0;
    mark_wr  = 1'b0;
    len_roll = 1'b0;
    case (state)
      ST_FILL: begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_dat  = bus.s_last ? padded : bus.s_data;
          len_add = bus.s_last ? 64'({bus.s_nbytes, 3'b000}) : 64'd32;
          if (!bus.s_last) begin
            if (wi == 4'd15) begin
              state_nx = ST_HASH;
              ret_nx   = ST_FILL;
            end
          end else if (bus.s_nbytes >= 3'd4) begin
            // Full last word: the marker goes into the next slot, possibly of a new block.
            if (wi == 4'd15) begin
              state_nx = ST_HASH;
              ret_nx   = ST_MARK;
            end else begin
              state_nx = ST_MARK;
            end
          end else begin
            mark_wr = 1'b1;
            if (wi == 4'd15) begin
              state_nx = ST_HASH;
              ret_nx   = ST_PAD;
            end else begin
              state_nx = ST_PAD;
            end
          end
        end
      end
      ST_MARK: begin
        wr_en   = 1'b1;
        wr_dat  = 32'h8000_0000;
        mark_wr = 1'b1;
        if (wi == 4'd15) begin
          state_nx = ST_HASH;
          ret_nx   = ST_PAD;
        end else begin
          state_nx = ST_PAD;
        end
      end
      ST_PAD: begin
        wr_en = 1'b1;
        if (wi == 4'd14) begin
          wr_dat = len_ok ? len[63:32] : '0;
        end else if (wi == 4'd15) begin
          // Without room for the length this block closes with zeros and a fresh one follows.
          wr_dat   = len_ok ? len[31:0] : '0;
          state_nx = ST_HASH;
          ret_nx   = len_ok ? ST_OUT : ST_PAD;
          len_roll = !len_ok;
        end
      end
      ST_HASH: begin
        if (bus.core_done) begin
          h_load   = 1'b1;
          wi_clr   = 1'b1;
          state_nx = ret;
          dig_load = (ret == ST_OUT);
        end
      end
      ST_OUT: begin
        if (bus.digest_ready) begin
          h_init   = 1'b1;
          state_nx = ST_FILL;
        end
      end
      default: state_nx = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wi     <= '0;
      len    <= '0;
      h      <= H0;
      dig    <= '0;
      start  <= 1'b0;
      len_ok <= 1'b0;
      for (int k = 0; k < BLK_WORDS; k++) begin
        blk[k] <= '0;
      end
    end else begin
      start <= (state != ST_HASH) && (state_nx == ST_HASH);
      if (wr_en) begin
        blk[wi] <= wr_dat;
      end
      if (wi_clr) begin
        wi <= '0;
      end else if (wr_en) begin
        wi <= wi + 4'd1;
      end
      len <= h_init ? '0 : len + len_add;
      if (h_init) begin
        h <= H0;
      end else if (h_load) begin
        h <= bus.core_H_out;
      end
      if (dig_load) begin
        dig <= bus.core_H_out;
      end
      // The length fits behind the marker unless the marker took word 14.
      if (mark_wr) begin
        len_ok <= (wi != 4'd14);
      end else if (len_roll) begin
        len_ok <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder with a behavioural compression core and a digest scoreboard.
module tb_sha256_msg_feeder;
  import sha256_pkg::*;

  localparam logic [255:0] IV_TB =
    256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19;
  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_56 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sha256_msg_feeder_if bus ();

  sha256_msg_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_starts = 0;
  logic [255:0] exp_q [$];
  logic [511:0] blk_q [$];
  logic [7:0]   msg [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    {a, b, c, d, e, f, g, hh} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
            e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   hh + hin[31:0]};
  endfunction

  function automatic logic [31:0] blkword(input int bi, input int k);
    logic [511:0] m;
    if (bi >= blk_q.size()) return 32'hDEAD_BEEF;
    m = blk_q[bi];
    return m[511-32*k -: 32];
  endfunction

  // Compression core model: answers each start after a few cycles, checking its inputs hold.
  initial begin
    logic [255:0] hin, hout;
    logic [511:0] m;
    logic stable;
    int lat;
    bus.core_done  = 1'b0;
    bus.core_H_out = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.core_start) begin
        hin = bus.core_H_in;
        m   = bus.core_M_in;
        n_starts++;
        blk_q.push_back(m);
        hout   = sha_compress(hin, m);
        lat    = 3 + (n_starts % 3);
        stable = 1'b1;
        repeat (lat) begin
          @(negedge clk);
          if (bus.core_M_in !== m || bus.core_H_in !== hin) stable = 1'b0;
        end
        check("core_inputs_stable", 256'(stable), 256'(1));
        bus.core_done  = 1'b1;
        bus.core_H_out = hout;
        @(negedge clk);
        bus.core_done  = 1'b0;
      end
    end
  end

  // Digest monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.digest_valid && bus.digest_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_digest", bus.digest, 256'h0);
        end else begin
          check("digest", bus.digest, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int c = 0;
    logic acc = 1'b0;
    bus.s_valid  = 1'b1;
    bus.s_data   = d;
    bus.s_last   = last;
    bus.s_nbytes = nb;
    while (!acc && c < 2000) begin
      @(negedge clk);
      acc = bus.s_ready;
      c++;
    end
    if (!acc) check("send_timeout", 256'(acc), 256'(1));
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_msg();
    int n  = msg.size();
    int nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] d = '0;
      int nb = n - 4*w;
      if (nb > 4) nb = 4;
      for (int b = 0; b < nb; b++) d[31-8*b -: 8] = msg[4*w+b];
      send_word(d, w == nw-1, 3'(nb));
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      check("digest_timeout", 256'(exp_q.size()), 256'(0));
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_abc(input string tag);
    int s0 = n_starts;
    blk_q.delete();
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    exp_q.push_back(D_ABC);
    send_msg();
    wait_idle();
    check({tag, "_starts"}, 256'(n_starts - s0), 256'(1));
    check({tag, "_w0"}, 256'(blkword(0, 0)), 256'(32'h6162_6380));
    check({tag, "_w15"}, 256'(blkword(0, 15)), 256'(32'h0000_0018));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [511:0] b1, b2;
    logic [255:0] d64;
    string s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

    rst_n = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.s_nbytes = '0;
    bus.digest_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 256'(bus.s_ready), 256'(0));
    check("rst_core_start", 256'(bus.core_start), 256'(0));
    check("rst_digest_valid", 256'(bus.digest_valid), 256'(0));
    check("rst_digest", bus.digest, 256'h0);
    check("rst_core_H_in", bus.core_H_in, IV_TB);
    check("rst_core_M_in", 256'(|bus.core_M_in), 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_rst", 256'(bus.s_ready), 256'(1));
    @(posedge clk);
    #1;

    run_abc("abc");

    // Empty message
    s0 = n_starts;
    blk_q.delete();
    msg.delete();
    exp_q.push_back(D_EMPTY);
    send_msg();
    wait_idle();
    check("empty_starts", 256'(n_starts - s0), 256'(1));
    check("empty_w0", 256'(blkword(0, 0)), 256'(32'h8000_0000));
    check("empty_w15", 256'(blkword(0, 15)), 256'(0));

    // 56 bytes: marker lands in word 14, length needs a second block
    s0 = n_starts;
    blk_q.delete();
    msg.delete();
    for (int i = 0; i < s56.len(); i++) msg.push_back(s56[i]);
    exp_q.push_back(D_56);
    send_msg();
    wait_idle();
    check("m56_starts", 256'(n_starts - s0), 256'(2));
    check("m56_b0_w14", 256'(blkword(0, 14)), 256'(32'h8000_0000));
    check("m56_b1_w0", 256'(blkword(1, 0)), 256'(0));
    check("m56_b1_w15", 256'(blkword(1, 15)), 256'(32'h0000_01c0));

    // 64 bytes 0x00..0x3f: second block is marker plus length only
    s0 = n_starts;
    blk_q.delete();
    msg.delete();
    for (int i = 0; i < 64; i++) begin
      msg.push_back(8'(i));
      b1[511-8*i -: 8] = 8'(i);
    end
    b2  = {32'h8000_0000, 416'h0, 64'd512};
    d64 = sha_compress(sha_compress(IV_TB, b1), b2);
    exp_q.push_back(d64);
    send_msg();
    wait_idle();
    check("m64_starts", 256'(n_starts - s0), 256'(2));
    check("m64_b1_w0", 256'(blkword(1, 0)), 256'(32'h8000_0000));
    check("m64_b1_w15", 256'(blkword(1, 15)), 256'(32'h0000_0200));

    // Downstream stall, then release with the next word already waiting
    begin
      int c = 0;
      bus.digest_ready = 1'b0;
      blk_q.delete();
      msg.delete();
      msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
      exp_q.push_back(D_ABC);
      send_msg();
      while (!bus.digest_valid && c < 3000) begin
        @(negedge clk);
        c++;
      end
      check("stall_valid_seen", 256'(bus.digest_valid), 256'(1));
      for (int i = 0; i < 10; i++) begin
        check("stall_digest", bus.digest, D_ABC);
        check("stall_s_ready", 256'(bus.s_ready), 256'(0));
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      exp_q.push_back(D_EMPTY);
      bus.digest_ready = 1'b1;
      bus.s_valid  = 1'b1;
      bus.s_data   = '0;
      bus.s_last   = 1'b1;
      bus.s_nbytes = 3'd0;
      @(negedge clk);
      check("hs_cycle_s_ready", 256'(bus.s_ready), 256'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("accept_after_hs", 256'(bus.s_ready), 256'(1));
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      wait_idle();
    end

    // Abort a partially filled block with a one-cycle reset
    send_word(32'h1111_1111, 1'b0, 3'd4);
    send_word(32'h2222_2222, 1'b0, 3'd4);
    send_word(32'h3333_3333, 1'b0, 3'd4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_M_cleared", 256'(|bus.core_M_in), 256'(0));
    check("abort_s_ready", 256'(bus.s_ready), 256'(1));
    @(posedge clk);
    #1;
    run_abc("abc_after_abort");

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_feeder.md
# sha256_msg_feeder

Front-end controller for the SHA-256 compression core: it accepts a big-endian 32-bit message word stream and performs FIPS 180-4 padding and length appending. It assembles 512-bit blocks, drives the core one block at a time with the running chaining value, and collects each result. It sits between the Hash160 top-level data path and the compression core, and presents the final 256-bit digest on a valid/ready output.

## Interface
Parameters:
- `H0`, default `256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19`: initial chaining value loaded at each message start.

Ports:
- `clk`, in, 1: single clock, all logic on rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `s_valid`, in, 1: message word valid.
- `s_ready`, out, 1: feeder accepts a word.
- `s_data`, in, 32: message word; first byte in [31:24].
- `s_last`, in, 1: final word of the message.
- `s_nbytes`, in, 3: valid bytes in the word, 0..4. Meaningful only with `s_last`; non-last words are always 4 bytes.
- `core_H_in`, out, 256: chaining value to the core, held stable from `core_start` until `core_done`.
- `core_M_in`, out, 512: padded block, word 0 in [511:480], held stable likewise.
- `core_start`, out, 1: one-cycle pulse launching a compression.
- `core_done`, in, 1: one-cycle pulse; `core_H_out` is valid (feed-forward included).
- `core_H_out`, in, 256: new chaining value.
- `digest`, out, 256: final hash.
- `digest_valid`, out, 1: digest available.
- `digest_ready`, in, 1: downstream accepts digest.

## Operation
- Block buffer: 16×32 registers plus a 4-bit word index `wi`. Message bit counter `len`: 64 bits, adds 8·nbytes per accepted word.
- States:
  - FILL: `s_ready`=1. An accepted word is stored at `wi`, then `wi`++.
    - Non-last word with `wi`=15: go to HASH, with return state FILL.
    - Last word, nbytes<4: bytes beyond nbytes are zeroed and byte nbytes is set to 0x80; go to PAD.
    - Last word, nbytes=4: go to MARK.
  - MARK: write 0x80000000 at `wi`, then `wi`++. Go to PAD, or to HASH if `wi` was 15. Record `need_len`=1.
  - PAD: write zeros until `wi`=14, then write {len[63:32], len[31:0]} into words 14 and 15 and go to HASH, with return state OUT.
    - If the marker landed in word 14 or 15, zero-fill to word 15, go to HASH, and return to PAD with a fresh zero block.
  - HASH: pulse `core_start` on entry. Wait for `core_done`, then set H ← `core_H_out`, set `wi` ← 0, and go to the return state.
  - OUT: `digest_valid`=1, `digest`=H. On handshake, load H ← H0, clear `len`, and go to FILL.
- On message start, H = H0 is already loaded: at reset and again after each OUT.
- `s_nbytes`=0 with `s_last` is legal: either an empty message, or a message ending on the previous word boundary. The 0x80 marker is placed in that word.
- Lengths ≥2^61 bytes are not supported: `len` wraps and no error is raised.

## Timing
- Reset values: `s_ready`=0 during reset and 1 in the first cycle after; `core_start`=0; `digest_valid`=0; `digest`=0; `core_H_in`=H0; `core_M_in`=0; state FILL.
- Throughput: one word per cycle in FILL. `s_ready`=0 in MARK, PAD, HASH and OUT.
- PAD and MARK each write one word per cycle.
- `core_start` asserts the cycle after the block's final word is written. The next FILL acceptance is the cycle after `core_done`.
- `digest_valid` rises the cycle after the final `core_done`. It holds with `digest` stable until `digest_ready`. `s_ready` rises the cycle after the handshake.
- A `core_done` that arrives outside HASH is ignored.
- Reset mid-operation aborts the message and restores the reset values. The core must be reset in the same cycle.

## Structure
- Shared `sha256_pkg` holds: the `H0` IV constant, the state enum (FILL, MARK, PAD, HASH, OUT), and the block/word width constants. The SHA-256 K table also moves here.
- One combinational sub-module, `sha256_pad_word`: given (data, nbytes), it returns the masked word with the 0x80 marker inserted.

## Test plan
- "abc": one word 0x61626300, nbytes=3, last → one `core_start`; block word 15 = 0x00000018; digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9c b410ff61f20015ad.
- Empty message: one word, nbytes=0, last → word 0 = 0x80000000, `len`=0; digest e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- 56-byte "abcdbcdecdefdefg…nopq": 14 full words, last with nbytes=4 → marker in word 14, two `core_start`; digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- 64-byte message → block 2 has word 0 = 0x80000000 and word 15 = 0x00000200; exactly two core pulses.
- Hold `digest_ready`=0 for 10 cycles → `digest` stays stable and `s_ready`=0 throughout. Then release with `s_valid` held high → the first word is accepted the cycle after the handshake.
- Drop `rst_n` for one cycle in mid-FILL, then send "abc" → the "abc" digest, with no residue from the aborted message.
